pass_rom_controller: RTL and testbench

PASS_ROM_CONTROLLER -- requirements
Module: pass_rom_controller

---
 rtl/pass_rom_controller_pkg.sv | 48 ++++
 rtl/pass_rom_controller_rom_pass.sv | 22 ++
 rtl/pass_rom_controller.sv | 161 ++++++++++++++++
 tb/tb_pass_rom_controller.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/pass_rom_controller_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | pass_rom_controller_pkg                                          |
// | Shared types and constants for the password ROM controller.      |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package pass_rom_controller_pkg;

  localparam int c_digits_default = 4;
  localparam int c_rom_depth      = 64;
  localparam int c_rom_addr_w     = 6;
  localparam int c_rom_data_w     = 8;
  localparam int c_idx_w          = 4;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_FETCH      = 3'd1,
    ST_WAIT_KEY   = 3'd2,
    ST_WAIT_POUND = 3'd3,
    ST_GRANT      = 3'd4,
    ST_DENY       = 3'd5
  } state_t;

  // Stored password table. For user 2 every digit is C except the last one,
  // which keeps the table meaningful when DIGITS is not 4.
  function automatic logic [c_rom_data_w-1:0] rom_word(
    input logic [c_rom_addr_w-1:0] addr,
    input int                      digits
  );
    int         u;
    int         k;
    logic [3:0] d;
    u = int'(addr[5:3]);
    k = int'(addr[2:0]);
    d = 4'h0;
    if (k < digits) begin
      case (u)
        0:       d = 4'(k + 1);
        1:       d = 4'h0;
        2:       d = (k == digits - 1) ? 4'h1 : 4'hC;
        default: d = 4'(u);
      endcase
    end
    return {4'h0, d};
  endfunction

endpackage
`default_nettype wire

// File: rtl/pass_rom_controller_rom_pass.sv
`default_nettype none
// +------------------------------------------------------------------+
// | rom_pass                                                         |
// | 64x8 synchronous password ROM, one-cycle read latency.           |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module rom_pass
  import pass_rom_controller_pkg::*;
#(
  parameter int DIGITS = c_digits_default
) (
  input  logic [c_rom_addr_w-1:0] address,
  input  logic                    clock,
  output logic [c_rom_data_w-1:0] q
);

  always_ff @(posedge clock) begin
    q <= rom_word(address, DIGITS);
  end

endmodule
`default_nettype wire

// File: rtl/pass_rom_controller.sv
`default_nettype none
// +------------------------------------------------------------------+
// | pass_rom_controller                                              |
// | Keypad password checker reading per-user digits from a ROM.      |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module pass_rom_controller
  import pass_rom_controller_pkg::*;
#(
  parameter int DIGITS = c_digits_default
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pass_allow,
  input  logic [2:0] address_user,
  input  logic [3:0] pass_input,
  input  logic       pass_load,
  input  logic       pass_pound,
  output logic [5:0] address_pass,
  output logic [7:0] q_pwd,
  output logic       allow,
  output logic       flag,
  output logic       wrong_pwd
);

  localparam logic [c_idx_w-1:0] c_digits = c_idx_w'(DIGITS);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [2:0]         r_user;
  logic [2:0]         w_user_nxt;
  logic [c_idx_w-1:0] r_idx;
  logic [c_idx_w-1:0] w_idx_nxt;
  logic [c_idx_w-1:0] w_idx_inc;
  logic               r_err;
  logic               w_err_nxt;
  logic               r_allow;
  logic               w_allow_nxt;
  logic               r_wrong;
  logic               w_wrong_nxt;
  logic               r_flag;
  logic               w_flag_nxt;
  logic               r_load_q;
  logic               r_pound_q;
  logic               w_load_rise;
  logic               w_pound_fall;
  logic               w_grant;

  assign w_load_rise  = pass_load & ~r_load_q;
  assign w_pound_fall = ~pass_pound & r_pound_q;
  assign w_idx_inc    = r_idx + 1'b1;
  assign w_grant      = (r_idx == c_digits) && !r_err;

  assign address_pass = {r_user, r_idx[2:0]};
  assign allow        = r_allow;
  assign wrong_pwd    = r_wrong;
  assign flag         = r_flag;

  rom_pass #(
    .DIGITS(DIGITS)
  ) u_rom (
    .address(address_pass),
    .clock  (clk),
    .q      (q_pwd)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= ST_IDLE;
      r_user    <= 3'd0;
      r_idx     <= '0;
      r_err     <= 1'b0;
      r_allow   <= 1'b0;
      r_wrong   <= 1'b0;
      r_flag    <= 1'b0;
      r_load_q  <= 1'b0;
      r_pound_q <= 1'b1;
    end else begin
      r_state   <= w_state_nxt;
      r_user    <= w_user_nxt;
      r_idx     <= w_idx_nxt;
      r_err     <= w_err_nxt;
      r_allow   <= w_allow_nxt;
      r_wrong   <= w_wrong_nxt;
      r_flag    <= w_flag_nxt;
      r_load_q  <= pass_load;
      r_pound_q <= pass_pound;
    end
  end

  // Load has priority over pound in both key-entry states.
  always_comb begin
    w_state_nxt = r_state;
    w_user_nxt  = r_user;
    w_idx_nxt   = r_idx;
    w_err_nxt   = r_err;
    w_allow_nxt = r_allow;
    w_wrong_nxt = r_wrong;
    w_flag_nxt  = 1'b0;

    if (!pass_allow) begin
      w_state_nxt = ST_IDLE;
      w_idx_nxt   = '0;
      w_err_nxt   = 1'b0;
      w_allow_nxt = 1'b0;
      w_wrong_nxt = 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_idx_nxt   = '0;
          w_err_nxt   = 1'b0;
          w_user_nxt  = address_user;
          w_state_nxt = ST_FETCH;
        end
        ST_FETCH: begin
          w_state_nxt = ST_WAIT_KEY;
        end
        ST_WAIT_KEY: begin
          if (w_load_rise) begin
            if (pass_input != q_pwd[3:0]) begin
              w_err_nxt = 1'b1;
            end
            w_idx_nxt   = w_idx_inc;
            w_state_nxt = (w_idx_inc == c_digits) ? ST_WAIT_POUND : ST_FETCH;
          end else if (w_pound_fall) begin
            w_flag_nxt = 1'b1;
            if (w_grant) begin
              w_state_nxt = ST_GRANT;
              w_allow_nxt = 1'b1;
            end else begin
              w_state_nxt = ST_DENY;
              w_wrong_nxt = 1'b1;
            end
          end
        end
        ST_WAIT_POUND: begin
          if (w_load_rise) begin
            w_err_nxt = 1'b1;
          end else if (w_pound_fall) begin
            w_flag_nxt = 1'b1;
            if (w_grant) begin
              w_state_nxt = ST_GRANT;
              w_allow_nxt = 1'b1;
            end else begin
              w_state_nxt = ST_DENY;
              w_wrong_nxt = 1'b1;
            end
          end
        end
        ST_GRANT, ST_DENY: begin
          w_state_nxt = r_state;
        end
        default: begin
          w_state_nxt = ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pass_rom_controller.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_pass_rom_controller                                           |
// | Randomized scoreboard bench for the password ROM controller.     |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_pass_rom_controller;

  localparam int DIGITS = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       pass_allow;
  logic [2:0] address_user;
  logic [3:0] pass_input;
  logic       pass_load;
  logic       pass_pound;
  logic [5:0] address_pass;
  logic [7:0] q_pwd;
  logic       allow;
  logic       flag;
  logic       wrong_pwd;

  int   n_checks = 0;
  int   n_pass   = 0;
  int   verdicts = 0;
  bit   exp_q[$];
  bit   mon_e;
  logic prev_flag = 1'b0;
  logic [3:0] keys [8];

  pass_rom_controller #(
    .DIGITS(DIGITS)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .pass_allow  (pass_allow),
    .address_user(address_user),
    .pass_input  (pass_input),
    .pass_load   (pass_load),
    .pass_pound  (pass_pound),
    .address_pass(address_pass),
    .q_pwd       (q_pwd),
    .allow       (allow),
    .flag        (flag),
    .wrong_pwd   (wrong_pwd)
  );

  always #5 clk = ~clk;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endfunction

  // Reference password table.
  function automatic logic [3:0] ref_digit(input int u, input int k);
    int pw0 [4] = '{1, 2, 3, 4};
    int pw2 [4] = '{12, 12, 12, 1};
    case (u)
      0:       return 4'(pw0[k]);
      1:       return 4'h0;
      2:       return 4'(pw2[k]);
      default: return 4'(u);
    endcase
  endfunction

  // Scoreboard monitor: each verdict pulse consumes one expected outcome.
  always @(negedge clk) begin
    if (rst === 1'b1 && flag === 1'b1) begin
      check("flag_single_cycle", 32'(prev_flag), 32'd0);
      check("verdict_expected", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        check("verdict_allow", 32'(allow), 32'(mon_e));
        check("verdict_wrong_pwd", 32'(wrong_pwd), 32'(!mon_e));
      end
      verdicts++;
    end
    prev_flag = flag;
  end

  task automatic start_entry(input int user);
    pass_allow   = 1'b1;
    address_user = 3'(user);
    @(negedge clk); #1;
    address_user = 3'($urandom_range(0, 7));
    @(negedge clk); #1;
  endtask

  task automatic press(input logic [3:0] key, input int hold);
    pass_input = key;
    pass_load  = 1'b1;
    repeat (hold) @(negedge clk);
    #1;
    pass_load  = 1'b0;
    pass_input = 4'($urandom_range(0, 15));
    repeat (2) @(negedge clk);
    #1;
  endtask

  task automatic run_session(input int user, input int n, input int hold);
    bit grant;
    int target;
    int idx_exp;
    start_entry(user);
    grant = (n == DIGITS);
    for (int k = 0; k < n; k++) begin
      if (k < DIGITS) begin
        check("rom_q_pwd", 32'(q_pwd), 32'({4'h0, ref_digit(user, k)}));
        check("address_pass", 32'(address_pass), 32'({3'(user), 3'(k)}));
        if (keys[k] != ref_digit(user, k)) grant = 1'b0;
      end
      press(keys[k], hold);
    end
    idx_exp = (n < DIGITS) ? n : DIGITS;
    check("address_after_keys", 32'(address_pass), 32'({3'(user), 3'(idx_exp)}));
    exp_q.push_back(grant);
    target = verdicts + 1;
    pass_pound = 1'b0;
    @(negedge clk); #1;
    pass_pound = 1'b1;
    for (int i = 0; i < 10 && verdicts < target; i++) begin
      @(negedge clk); #1;
    end
    if (verdicts < target) begin
      check("verdict_timeout", 32'(verdicts), 32'(target));
      if (exp_q.size() > 0) void'(exp_q.pop_front());
    end
    repeat (3) @(negedge clk);
    #1;
    check("allow_sticky", 32'(allow), 32'(grant));
    check("wrong_pwd_sticky", 32'(wrong_pwd), 32'(!grant));
    check("flag_idle", 32'(flag), 32'd0);
    pass_allow = 1'b0;
    @(negedge clk); #1;
    check("allow_cleared", 32'(allow), 32'd0);
    check("wrong_pwd_cleared", 32'(wrong_pwd), 32'd0);
    @(negedge clk); #1;
  endtask

  task automatic set_correct(input int user);
    for (int k = 0; k < 8; k++) keys[k] = (k < DIGITS) ? ref_digit(user, k) : 4'($urandom_range(0, 15));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int u;
    int n;
    rst          = 1'b0;
    pass_allow   = 1'b0;
    address_user = 3'd0;
    pass_input   = 4'd0;
    pass_load    = 1'b0;
    pass_pound   = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_address_pass", 32'(address_pass), 32'd0);
    check("reset_allow", 32'(allow), 32'd0);
    check("reset_flag", 32'(flag), 32'd0);
    check("reset_wrong_pwd", 32'(wrong_pwd), 32'd0);
    #1 rst = 1'b1;
    @(negedge clk); #1;

    set_correct(2);
    run_session(2, 4, 1);
    keys[3] = 4'h2;
    run_session(2, 4, 1);
    set_correct(0);
    run_session(0, 2, 1);
    set_correct(2);
    run_session(2, 5, 1);
    run_session(2, 1, 5);

    // Reset in the middle of an entry discards the digits already typed.
    set_correct(2);
    start_entry(2);
    press(keys[0], 1);
    press(keys[1], 1);
    #2 rst = 1'b0;
    #1;
    check("midreset_address_pass", 32'(address_pass), 32'd0);
    check("midreset_allow", 32'(allow), 32'd0);
    check("midreset_wrong_pwd", 32'(wrong_pwd), 32'd0);
    pass_allow = 1'b0;
    @(negedge clk); #1;
    rst = 1'b1;
    @(negedge clk); #1;
    run_session(2, 4, 1);

    for (int s = 0; s < 20; s++) begin
      u = $urandom_range(0, 7);
      n = ($urandom_range(0, 3) != 0) ? DIGITS : $urandom_range(0, 5);
      set_correct(u);
      for (int k = 0; k < DIGITS; k++) begin
        if ($urandom_range(0, 5) == 0) keys[k] = 4'($urandom_range(0, 15));
      end
      run_session(u, n, $urandom_range(1, 3));
    end

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
